vga_timing_gen: RTL

//  Generates 640x480@60 VGA raster timing from the 100 MHz system clock.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_prescaler.sv | 37 +++
 rtl/vga_timing_gen.sv | 110 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared types and 640x480@60 timing constants for the VGA raster generator.
package vga_pkg;

    typedef logic [11:0] rgb12_t;

    localparam int CNT_W         = 10;
    localparam int VGA_CLK_DIV   = 4;
    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FP      = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BP      = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FP      = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BP      = 33;

    function automatic int h_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    function automatic int v_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_prescaler.sv
// Divides the system clock down to a one-clock pixel strobe every CLK_DIV clocks.
module vga_prescaler #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_tick
);

    localparam logic [3:0] LAST = 4'(CLK_DIV - 1);

    logic [3:0] presc_q;
    logic [3:0] presc_d;

    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_prescaler: CLK_DIV must be in 1..16");
    end

    always_comb begin
        presc_d = presc_q + 4'd1;
        if (presc_q == LAST) begin
            presc_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= 4'd0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // Gated by rst_n so no tick is seen while reset is asserted.
    assign pix_tick = rst_n && (presc_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters, sync decode and a one-pixel output register stage that
// keeps colour and syncs aligned at the DAC.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = VGA_CLK_DIV,
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             video_on,
    output logic             pix_tick,
    output logic             frame_end,
    input  rgb12_t           rgb_in,
    output rgb12_t           rgb_out,
    output logic             hsync,
    output logic             vsync
);

    localparam int H_TOTAL = h_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic             SYNC_IDLE  = ~SYNC_POL;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must both be <= 1024");
    end

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    rgb12_t           rgb_q, rgb_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             hs_window;
    logic             vs_window;

    vga_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix_tick (pix_tick)
    );

    assign video_on  = (h_q < H_VIS) && (v_q < V_VIS);
    assign hs_window = (h_q >= HS_START) && (h_q <= HS_END);
    assign vs_window = (v_q >= VS_START) && (v_q <= VS_END);
    assign frame_end = pix_tick && (h_q == H_LAST) && (v_q == V_LAST);

    always_comb begin
        h_d  = h_q;
        v_d  = v_q;
        rgb_d = rgb_q;
        hs_d = hs_q;
        vs_d = vs_q;
        if (pix_tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
            // Output stage registers the pixel the counters are leaving.
            rgb_d = video_on ? rgb_in : 12'h000;
            hs_d  = hs_window ^ SYNC_IDLE;
            vs_d  = vs_window ^ SYNC_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_q   <= '0;
            v_q   <= '0;
            rgb_q <= 12'h000;
            hs_q  <= SYNC_IDLE;
            vs_q  <= SYNC_IDLE;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            rgb_q <= rgb_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
        end
    end

    assign h_count = h_q;
    assign v_count = v_q;
    assign rgb_out = rgb_q;
    assign hsync   = hs_q;
    assign vsync   = vs_q;

endmodule
